// File: rtl/packet_receiver_if.sv
// Bit-stream in / byte-stream out bundle between the demodulator and the
// packet receiver. Widths follow the packet length in bits.
interface packet_receiver_if #(
    parameter int PACKET_SIZE = 128
);
    localparam int IDX_W = $clog2(PACKET_SIZE / 8);

    logic             bit_in;
    logic             bit_valid;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic [IDX_W-1:0] byte_index;
    logic [IDX_W:0]   msg_len;
    logic             packet_done;
    logic             frame_error;

    // Bit source side (demodulator, or a testbench standing in for it)
    modport master (
        output bit_in, bit_valid,
        input  byte_out, byte_valid, byte_index, msg_len, packet_done, frame_error
    );

    // Receiver side
    modport slave (
        input  bit_in, bit_valid,
        output byte_out, byte_valid, byte_index, msg_len, packet_done, frame_error
    );
endinterface

// File: rtl/packet_receiver.sv
// Byte-level receive framer: hunts for the sync character in the recovered
// bit stream, deserializes MSB-first bytes, tracks message length up to the
// first 0x00, and reports packet completion or a stalled-stream abort.
module packet_receiver #(
    parameter int         PACKET_SIZE = 128,
    parameter logic [7:0] SYNC_BYTE   = 8'h48,
    parameter int         TIMEOUT     = 4096
) (
    input logic              clock,
    input logic              reset_n,
    packet_receiver_if.slave rx
);
    localparam int NBYTES = PACKET_SIZE / 8;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam int CNT_W  = $clog2(PACKET_SIZE) + 1;
    localparam int TMO_W  = $clog2(TIMEOUT);

    localparam logic [IDX_W:0]   MSG_MAX  = (IDX_W + 1)'(NBYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACKET_SIZE);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_RECEIVE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // Only the 7 most recent bits need storing: the incoming bit completes
    // the 8-bit window combinationally.
    logic [1:0]       state_q,       state_d;
    logic [6:0]       shift_q,       shift_d;
    logic [CNT_W-1:0] bit_cnt_q,     bit_cnt_d;
    logic [TMO_W-1:0] tmo_q,         tmo_d;
    logic             term_seen_q,   term_seen_d;
    logic [7:0]       byte_out_q,    byte_out_d;
    logic             byte_valid_q,  byte_valid_d;
    logic [IDX_W-1:0] byte_index_q,  byte_index_d;
    logic [IDX_W:0]   msg_len_q,     msg_len_d;
    logic             packet_done_q, packet_done_d;
    logic             frame_error_q, frame_error_d;

    logic [7:0]       window;
    logic [CNT_W-1:0] bit_cnt_inc;

    assign window      = {shift_q, rx.bit_in};
    assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);

    // Next-state logic for the hunt / receive / done sequence and all outputs
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        tmo_d         = tmo_q;
        term_seen_d   = term_seen_q;
        byte_out_d    = byte_out_q;
        byte_valid_d  = 1'b0;
        byte_index_d  = byte_index_q;
        msg_len_d     = msg_len_q;
        packet_done_d = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (rx.bit_valid) begin
                    shift_d = window[6:0];
                    if (window == SYNC_BYTE) begin
                        byte_out_d   = window;
                        byte_valid_d = 1'b1;
                        byte_index_d = '0;
                        bit_cnt_d    = CNT_W'(8);
                        msg_len_d    = (IDX_W + 1)'(1);
                        term_seen_d  = 1'b0;
                        tmo_d        = '0;
                        state_d      = ST_RECEIVE;
                    end
                end
            end

            ST_RECEIVE: begin
                if (rx.bit_valid) begin
                    // A bit arriving on the last allowed cycle still counts
                    shift_d   = window[6:0];
                    bit_cnt_d = bit_cnt_inc;
                    tmo_d     = '0;
                    if (bit_cnt_inc[2:0] == 3'd0) begin
                        byte_out_d   = window;
                        byte_valid_d = 1'b1;
                        byte_index_d = IDX_W'((bit_cnt_inc >> 3) - CNT_W'(1));
                        if (!term_seen_q) begin
                            if (window == 8'h00) begin
                                term_seen_d = 1'b1;
                            end else if (msg_len_q != MSG_MAX) begin
                                msg_len_d = msg_len_q + (IDX_W + 1)'(1);
                            end
                        end
                        if (bit_cnt_inc == CNT_LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    frame_error_d = 1'b1;
                    shift_d       = '0;
                    bit_cnt_d     = '0;
                    tmo_d         = '0;
                    state_d       = ST_HUNT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_DONE: begin
                // Any bit strobe here is dropped; the hunt restarts clean
                packet_done_d = 1'b1;
                shift_d       = '0;
                bit_cnt_d     = '0;
                tmo_d         = '0;
                state_d       = ST_HUNT;
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_HUNT;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            tmo_q         <= '0;
            term_seen_q   <= 1'b0;
            byte_out_q    <= '0;
            byte_valid_q  <= 1'b0;
            byte_index_q  <= '0;
            msg_len_q     <= '0;
            packet_done_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            tmo_q         <= tmo_d;
            term_seen_q   <= term_seen_d;
            byte_out_q    <= byte_out_d;
            byte_valid_q  <= byte_valid_d;
            byte_index_q  <= byte_index_d;
            msg_len_q     <= msg_len_d;
            packet_done_q <= packet_done_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign rx.byte_out    = byte_out_q;
    assign rx.byte_valid  = byte_valid_q;
    assign rx.byte_index  = byte_index_q;
    assign rx.msg_len     = msg_len_q;
    assign rx.packet_done = packet_done_q;
    assign rx.frame_error = frame_error_q;
endmodule

// File: tb/tb_packet_receiver.sv
// Directed bench for packet_receiver: full packets at slow and full rate,
// hunt through garbage, stall abort, timeout tie, no terminator, mid reset.
module tb_packet_receiver;
    localparam int PACKET_SIZE = 128;
    localparam int TIMEOUT     = 4096;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    packet_receiver_if #(.PACKET_SIZE(PACKET_SIZE)) rx_if ();

    packet_receiver #(
        .PACKET_SIZE (PACKET_SIZE),
        .SYNC_BYTE   (8'h48),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .rx      (rx_if)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] val;
        int         idx;
        int         cyc;
    } byte_ev_t;

    byte_ev_t byte_q[$];
    int       done_len_q[$];
    int       done_cyc_q[$];
    int       fe_cyc_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int last_strobe = 0;
    int sync_cyc = 0;

    logic [7:0] pkt[16];
    logic [7:0] hello[16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77, 8'h6F,
                              8'h72, 8'h6C, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // Record output events away from the active edge
    always @(negedge clock) begin
        if (rx_if.byte_valid) begin
            byte_q.push_back('{val: rx_if.byte_out, idx: int'(rx_if.byte_index), cyc: cyc});
            $display("[TB] byte idx=%0d val=%02h cyc=%0d", rx_if.byte_index, rx_if.byte_out, cyc);
        end
        if (rx_if.packet_done) begin
            done_len_q.push_back(int'(rx_if.msg_len));
            done_cyc_q.push_back(cyc);
            $display("[TB] packet_done msg_len=%0d cyc=%0d", rx_if.msg_len, cyc);
        end
        if (rx_if.frame_error) begin
            fe_cyc_q.push_back(cyc);
            $display("[TB] frame_error cyc=%0d", cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_events();
        byte_q.delete();
        done_len_q.delete();
        done_cyc_q.delete();
        fe_cyc_q.delete();
    endtask

    // Called at a falling edge; leaves the strobe for one rising edge, then idles gap-1 cycles
    task automatic send_bit(input logic b, input int gap);
        rx_if.bit_in    = b;
        rx_if.bit_valid = 1'b1;
        @(negedge clock);
        rx_if.bit_valid = 1'b0;
        last_strobe     = cyc;
        repeat (gap - 1) @(negedge clock);
    endtask

    task automatic send_range(input int from, input int to, input int gap);
        for (int b = from; b < to; b++) begin
            send_bit(pkt[b / 8][7 - (b % 8)], gap);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " byte_out"},    32'(rx_if.byte_out),    32'd0);
        check({tag, " byte_valid"},  32'(rx_if.byte_valid),  32'd0);
        check({tag, " byte_index"},  32'(rx_if.byte_index),  32'd0);
        check({tag, " msg_len"},     32'(rx_if.msg_len),     32'd0);
        check({tag, " packet_done"}, 32'(rx_if.packet_done), 32'd0);
        check({tag, " frame_error"}, 32'(rx_if.frame_error), 32'd0);
    endtask

    task automatic check_pkt(input string tag, input int exp_len);
        repeat (5) @(negedge clock);
        check({tag, " nbytes"}, 32'(byte_q.size()), 32'd16);
        for (int i = 0; i < byte_q.size() && i < 16; i++) begin
            check($sformatf("%s byte%0d val", tag, i), 32'(byte_q[i].val), 32'(pkt[i]));
            check($sformatf("%s byte%0d idx", tag, i), 32'(byte_q[i].idx), 32'(i));
        end
        check({tag, " ndone"}, 32'(done_len_q.size()), 32'd1);
        if (done_len_q.size() > 0) begin
            check({tag, " msg_len"}, 32'(done_len_q[0]), 32'(exp_len));
            if (byte_q.size() == 16) begin
                check({tag, " done_cyc"}, 32'(done_cyc_q[0]), 32'(byte_q[15].cyc + 1));
            end
        end
        check({tag, " nframe_err"}, 32'(fe_cyc_q.size()), 32'd0);
        clear_events();
    endtask

    initial begin
        rx_if.bit_in    = 1'b0;
        rx_if.bit_valid = 1'b0;
        pkt = hello;

        // Reset state
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Full packet, one bit per 16 clocks
        send_range(0, 128, 16);
        check_pkt("slow", 11);

        // Garbage prefix 101, then the packet at full rate
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_range(0, 8, 1);
        sync_cyc = last_strobe;
        send_range(8, 128, 1);
        if (byte_q.size() > 0) begin
            check("garbage first_byte_cyc", 32'(byte_q[0].cyc), 32'(sync_cyc));
        end
        check_pkt("garbage", 11);

        // Stall after 40 bits
        send_range(0, 40, 2);
        for (int i = 0; i < TIMEOUT + 200; i++) begin
            if (fe_cyc_q.size() > 0) break;
            @(negedge clock);
        end
        repeat (5) @(negedge clock);
        check("stall nframe_err", 32'(fe_cyc_q.size()), 32'd1);
        if (fe_cyc_q.size() > 0) begin
            check("stall fe_cyc", 32'(fe_cyc_q[0]), 32'(last_strobe + TIMEOUT));
        end
        check("stall nbytes", 32'(byte_q.size()), 32'd5);
        for (int i = 0; i < byte_q.size() && i < 5; i++) begin
            check($sformatf("stall byte%0d val", i), 32'(byte_q[i].val), 32'(pkt[i]));
            check($sformatf("stall byte%0d idx", i), 32'(byte_q[i].idx), 32'(i));
        end
        check("stall ndone", 32'(done_len_q.size()), 32'd0);
        clear_events();
        send_range(0, 128, 1);
        check_pkt("after_stall", 11);

        // Timeout tie: next strobe lands exactly when the counter is at TIMEOUT-1
        send_range(0, 7, 1);
        send_bit(pkt[0][0], TIMEOUT);
        send_range(8, 128, 1);
        check_pkt("tie", 11);

        // No terminator: msg_len saturates at 16
        pkt[0] = 8'h48;
        for (int i = 1; i < 16; i++) pkt[i] = 8'h41;
        send_range(0, 128, 1);
        check_pkt("noterm", 16);

        // Reset mid-packet after 20 bits
        pkt = hello;
        send_range(0, 20, 1);
        check("premid msg_len", 32'(rx_if.msg_len), 32'd2);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check_outputs_zero("midreset");
        clear_events();
        send_range(20, 128, 1);
        repeat (5) @(negedge clock);
        check("midreset tail nbytes", 32'(byte_q.size()), 32'd0);
        check("midreset tail ndone", 32'(done_len_q.size()), 32'd0);
        clear_events();
        send_range(0, 128, 1);
        check_pkt("after_reset", 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
